lcd_timing_gen: RTL



---
 rtl/lcd_timing_pkg.sv | 39 +++
 rtl/lcd_timing_gen_mod_counter.sv | 54 +++++
 rtl/lcd_timing_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - default LCD timing constants, derivations and FSM state encoding
//   Shared by lcd_timing_gen and its counter sub-module; no ports.
package lcd_timing_pkg;

  // Default 320x240 panel timing, in pixel ticks (horizontal) and lines (vertical).
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_H_FP     = 10;
  localparam int DEF_H_SYNC   = 20;
  localparam int DEF_H_BP     = 20;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 4;
  localparam int DEF_CW       = 10;

  // Period of one axis: active, front porch, sync, back porch in that order.
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First count inside the sync pulse.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // First count after the sync pulse.
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  typedef enum logic {
    ST_PARK = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/lcd_timing_gen_mod_counter.sv
// rtl/lcd_timing_gen_mod_counter.sv - modulo-MOD counter with park-at-MOD-1 clear
//   clk, rst_n      : clock, asynchronous active-low reset (count resets to MOD-1)
//   inc             : advance by one, wrapping MOD-1 -> 0
//   clear           : load MOD-1; overrides inc
//   count           : registered count
//   count_next      : value count takes at the next edge
//   wrap            : high in the cycle an inc wraps MOD-1 -> 0
module lcd_timing_gen_mod_counter
  import lcd_timing_pkg::*;
#(
  parameter int MOD = 8,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (clear) begin
      count_d = LAST;
    end else if (inc) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LAST;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - LCD horizontal/vertical timing generator driven by a pixel tick
//   iClk, iRst   : clock, asynchronous active-low reset
//   iEnable      : one-iClk pixel tick
//   iRun         : 1 = generate timing, 0 = park at (H_TOTAL-1, V_TOTAL-1)
//   oX, oY       : horizontal / vertical counters
//   oDe          : active-video flag
//   oHsync       : active-low horizontal sync
//   oVsync       : active-low vertical sync (whole lines)
//   oLineStart   : one-iClk pulse after the tick that made oX = 0
//   oFrameStart  : one-iClk pulse after the tick that made (oX, oY) = (0, 0)
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CW       = DEF_CW
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iEnable,
  input  logic          iRun,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          oDe,
  output logic          oHsync,
  output logic          oVsync,
  output logic          oLineStart,
  output logic          oFrameStart
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_ACT_C   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_S  = CW'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CW-1:0] H_SYNC_E  = CW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CW-1:0] V_SYNC_S  = CW'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CW-1:0] V_SYNC_E  = CW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  state_e state_q, state_d;

  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  logic          cnt_clear;
  logic          h_inc;
  logic [CW-1:0] h_count, h_next;
  logic [CW-1:0] v_count, v_next;
  logic          h_wrap, v_wrap;

  // Dropping iRun parks both counters immediately, even on a tick edge.
  // In PARK the counters already sit at (H_TOTAL-1, V_TOTAL-1), so the
  // first tick with iRun high wraps both to (0,0) with no special case.
  assign cnt_clear = !iRun;
  assign h_inc     = iRun && iEnable;

  lcd_timing_gen_mod_counter #(
    .MOD (H_TOTAL),
    .W   (CW)
  ) u_hcnt (
    .clk        (iClk),
    .rst_n      (iRst),
    .inc        (h_inc),
    .clear      (cnt_clear),
    .count      (h_count),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  lcd_timing_gen_mod_counter #(
    .MOD (V_TOTAL),
    .W   (CW)
  ) u_vcnt (
    .clk        (iClk),
    .rst_n      (iRst),
    .inc        (h_wrap),
    .clear      (cnt_clear),
    .count      (v_count),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  always_comb begin
    state_d = state_q;
    if (!iRun) begin
      state_d = ST_PARK;
    end else if (iEnable) begin
      state_d = ST_RUN;
    end
  end

  // Outputs decode the counters' next values so they update on the same
  // edge as the counters themselves.
  always_comb begin
    de_d          = 1'b0;
    hsync_d       = 1'b1;
    vsync_d       = 1'b1;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (state_d == ST_RUN) begin
      de_d          = (h_next < H_ACT_C) && (v_next < V_ACT_C);
      hsync_d       = !((h_next >= H_SYNC_S) && (h_next < H_SYNC_E));
      vsync_d       = !((v_next >= V_SYNC_S) && (v_next < V_SYNC_E));
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q       <= ST_PARK;
      de_q          <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign oX          = h_count;
  assign oY          = v_count;
  assign oDe         = de_q;
  assign oHsync      = hsync_q;
  assign oVsync      = vsync_q;
  assign oLineStart  = line_start_q;
  assign oFrameStart = frame_start_q;

endmodule
